// File: rtl/nios2_mul_seq_ctrl.sv
// nios2_mul_seq_ctrl
// Sequential 32x32 multiply controller built around a single 16x16 unsigned
// multiplier with a registered product. Signed forms are handled by working on
// operand magnitudes and negating the 64-bit sum at the end.
//
// Ports:
//   clk          - sole clock, rising-edge
//   reset        - synchronous active-high reset
//   req_valid    - request present
//   req_ready    - block can accept a request (IDLE only)
//   req_op       - 00 MUL (low 32), 01 MULXUU, 10 MULXSU, 11 MULXSS (high 32)
//   req_src1     - operand A
//   req_src2     - operand B
//   flush        - abandon the in-flight operation
//   rsp_valid    - result present
//   rsp_ready    - consumer accepts the result
//   rsp_result   - result, forced to 0 while rsp_valid is low
//   busy         - high whenever the controller is not IDLE
module nios2_mul_seq_ctrl #(
  parameter int SKIP_HH_FOR_MUL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [31:0] magA_q;
  logic [31:0] magB_q;
  logic        neg_q;
  logic [63:0] acc_q;
  logic [2:0]  partCnt_q;
  logic [31:0] prod_q;
  logic        reqReady_q;
  logic        rspValid_q;
  logic        busy_q;
  logic [31:0] rspResult_q;

  logic [31:0] magA_d;
  logic [31:0] magB_d;
  logic        neg_d;
  logic [2:0]  partTotal;
  logic [15:0] mulA;
  logic [15:0] mulB;
  logic [31:0] prod_d;
  logic [63:0] shiftedProd;
  logic [63:0] acc_d;
  logic [63:0] accFinal;
  logic [31:0] result_d;

  // Operand conditioning at accept time. Negating 0x80000000 wraps back to
  // 0x80000000, which is exactly the unsigned magnitude we want.
  always_comb begin
    magA_d = req_src1;
    magB_d = req_src2;
    neg_d  = 1'b0;
    if (req_op == OP_MULXSS) begin
      magA_d = req_src1[31] ? -req_src1 : req_src1;
      magB_d = req_src2[31] ? -req_src2 : req_src2;
      neg_d  = req_src1[31] ^ req_src2[31];
    end else if (req_op == OP_MULXSU) begin
      magA_d = req_src1[31] ? -req_src1 : req_src1;
      neg_d  = req_src1[31];
    end
  end

  // Partial-product datapath. The partial index is the counter value: bit 0
  // selects the high half of A and bit 1 the high half of B, which yields the
  // issue order ll, hl, lh, hh. The product waiting in prod_q belongs to the
  // previous index, so its shift comes from the counter value minus one; a
  // counter of zero means nothing of this operation has been multiplied yet,
  // so any stale product (e.g. left over from a flush) gets no weight.
  always_comb begin
    partTotal = (op_q == OP_MUL && SKIP_HH_FOR_MUL != 0) ? 3'd3 : 3'd4;
    mulA      = partCnt_q[0] ? magA_q[31:16] : magA_q[15:0];
    mulB      = partCnt_q[1] ? magB_q[31:16] : magB_q[15:0];
    prod_d    = {16'b0, mulA} * {16'b0, mulB};
    case (partCnt_q)
      3'd1:    shiftedProd = {32'b0, prod_q};
      3'd2:    shiftedProd = {16'b0, prod_q, 16'b0};
      3'd3:    shiftedProd = {16'b0, prod_q, 16'b0};
      3'd4:    shiftedProd = {prod_q, 32'b0};
      default: shiftedProd = 64'b0;
    endcase
    acc_d    = acc_q + shiftedProd;
    accFinal = neg_q ? -acc_d : acc_d;
    result_d = (op_q == OP_MUL) ? accFinal[31:0] : accFinal[63:32];
  end

  // Controller FSM with registered outputs. Reset outranks flush, and flush
  // outranks everything else outside IDLE. A flush in IDLE also blocks the
  // accept, which drops a request presented in that same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      magA_q      <= 32'b0;
      magB_q      <= 32'b0;
      neg_q       <= 1'b0;
      acc_q       <= 64'b0;
      partCnt_q   <= 3'd0;
      prod_q      <= 32'b0;
      reqReady_q  <= 1'b1;
      rspValid_q  <= 1'b0;
      busy_q      <= 1'b0;
      rspResult_q <= 32'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      reqReady_q  <= 1'b1;
      rspValid_q  <= 1'b0;
      busy_q      <= 1'b0;
      rspResult_q <= 32'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q    <= ISSUE;
            op_q       <= req_op;
            magA_q     <= magA_d;
            magB_q     <= magB_d;
            neg_q      <= neg_d;
            acc_q      <= 64'b0;
            partCnt_q  <= 3'd0;
            reqReady_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ISSUE: begin
          prod_q    <= prod_d;
          partCnt_q <= partCnt_q + 3'd1;
          if (partCnt_q != 3'd0) begin
            acc_q <= acc_d;
          end
          if (partCnt_q + 3'd1 == partTotal) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          acc_q       <= acc_d;
          rspResult_q <= result_d;
          rspValid_q  <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rspValid_q  <= 1'b0;
            rspResult_q <= 32'b0;
            reqReady_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b1;
          rspValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = reqReady_q;
  assign rsp_valid  = rspValid_q;
  assign rsp_result = rspResult_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_nios2_mul_seq_ctrl.sv
// Self-checking bench for nios2_mul_seq_ctrl: directed corner cases, flush,
// reset, back-to-back traffic and randomized operations compared against a
// plain 64-bit arithmetic reference.
module tb_nios2_mul_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;

  nios2_mul_seq_ctrl #(.SKIP_HH_FOR_MUL(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference result from full-width signed/unsigned 64-bit products.
  function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint signed sa;
    longint signed sb;
    longint signed ua;
    longint signed ub;
    logic [63:0]   p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      2'b00:   p = ua * ub;
      2'b01:   p = ua * ub;
      2'b10:   p = sa * ub;
      default: p = sa * sb;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // One complete operation, entered and left at a falling edge with the DUT
  // idle. Operands are scrambled right after accept, and the response is held
  // unacknowledged for holdCycles cycles before the handshake.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int holdCycles);
    int          cyc;
    int          expLat;
    logic [31:0] expRes;
    expRes = refMul(op, a, b);
    expLat = (op == 2'b00) ? 5 : 6;
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    checkOutput("accept_ready", {63'b0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_src1  = $urandom;
    req_src2  = $urandom;
    cyc = 1;
    checkOutput("inflight_flags", {62'b0, req_ready, busy}, 64'b01);
    while (!rsp_valid && cyc < 20) begin
      checkOutput("result_zero_while_invalid", {32'b0, rsp_result}, 64'b0);
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency", 64'(cyc), 64'(expLat));
    checkOutput("result", {32'b0, rsp_result}, {32'b0, expRes});
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("resp_hold", {30'b0, rsp_valid, req_ready, rsp_result},
                  {30'b0, 1'b1, 1'b0, expRes});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("post_handshake", {29'b0, req_ready, rsp_valid, busy, rsp_result},
                {29'b0, 1'b1, 1'b0, 1'b0, 32'b0});
  endtask

  // Watch a window of cycles in which no response may appear.
  task automatic expectNoResponse(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput(tag, {63'b0, seen}, 64'b0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src1  = 32'b0;
    req_src2  = 32'b0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", {29'b0, req_ready, rsp_valid, busy, rsp_result},
                {29'b0, 1'b1, 1'b0, 1'b0, 32'b0});
    reset = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    applyStimulus(2'b00, 32'h0001_0003, 32'h0002_0005, 0);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(2'b11, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    applyStimulus(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(2'b11, 32'h0000_0000, 32'hFFFF_FFFB, 0);
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Long backpressure, then a back-to-back request.
    applyStimulus(2'b01, 32'd3, 32'd5, 10);
    applyStimulus(2'b00, 32'd7, 32'd9, 0);

    // Flush two cycles after accept.
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_src1  = 32'h1234_5678;
    req_src2  = 32'h8765_4321;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_idle", {61'b0, busy, req_ready, rsp_valid}, 64'b010);
    expectNoResponse("flush_no_response", 8);
    applyStimulus(2'b00, 32'd2, 32'd3, 0);

    // Flush in the same cycle as a request in IDLE drops the request.
    req_valid = 1'b1;
    flush     = 1'b1;
    req_op    = 2'b01;
    req_src1  = 32'd11;
    req_src2  = 32'd13;
    checkOutput("flush_req_ready", {63'b0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("flush_drop_req", {62'b0, busy, req_ready}, 64'b01);
    expectNoResponse("flush_drop_no_response", 8);

    // Reset pulsed while the MUL operation is in DRAIN (4th cycle after accept).
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_src1  = 32'hDEAD_BEEF;
    req_src2  = 32'h0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_in_drain", {29'b0, req_ready, rsp_valid, busy, rsp_result},
                {29'b0, 1'b1, 1'b0, 1'b0, 32'b0});
    expectNoResponse("reset_no_response", 8);
    applyStimulus(2'b11, 32'hFFFF_FFF0, 32'h0000_0100, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(2'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
